sp_ram_arbiter: RTL and testbench

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

---
 rtl/sp_ram_arb_pkg.sv | 13 +
 rtl/sp_ram_arb_grant.sv | 32 +++
 rtl/sp_ram_arbiter.sv | 119 +++++++++++
 tb/tb_sp_ram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_arb_pkg.sv
// rtl/sp_ram_arb_pkg.sv - state encoding and access timing constants for sp_ram_arbiter
package sp_ram_arb_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CMD     = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;

    // Cycles spent in each non-idle state per access
    localparam int CMD_CYCLES     = 1;
    localparam int RD_WAIT_CYCLES = 1;

endpackage

// File: rtl/sp_ram_arb_grant.sv
// rtl/sp_ram_arb_grant.sv - one-hot grant search starting at a rotating pointer
module sp_ram_arb_grant
    import sp_ram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    // First asserted request at or after ptr, wrapping; a zero ptr gives lowest-index priority
    always_comb begin
        logic [PTR_W:0] sum;
        logic           found;
        grant = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req[sum[PTR_W-1:0]]) begin
                grant[sum[PTR_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// rtl/sp_ram_arbiter.sv - single-port RAM arbiter; SP_RAM_ARB_RR_EN selects round-robin over fixed priority
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_cs,
    output logic                          ram_we,
    output logic                          ram_oe,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic [DATA_WIDTH-1:0]         ram_rdata,
    output logic                          busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [1:0]            state;
    logic [PTR_W-1:0]      owner;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [PTR_W-1:0]      ptr;
    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      win_idx;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  handshake;

    sp_ram_arb_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_grant (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Grants are offered only when idle and out of reset, so a withdrawn valid drops its grant at once
    assign req_ready = (rst_n && state == ST_IDLE) ? grant : '0;
    assign handshake = |req_ready;

    // Select the winning requester's command fields
    always_comb begin
        win_idx   = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx   = PTR_W'(i);
                win_we    = req_we[i];
                win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef SP_RAM_ARB_RR_EN
    // Search pointer moves just past the last winner so every requester gets a turn
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (handshake) begin
            ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end
`else
    assign ptr = '0;
`endif

    // Access sequencer: capture on handshake, one command cycle, one read-return cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            owner   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        state   <= ST_CMD;
                        owner   <= win_idx;
                        we_q    <= win_we;
                        addr_q  <= win_addr;
                        wdata_q <= win_wdata;
                    end
                end
                ST_CMD:     state <= we_q ? ST_IDLE : ST_RD_WAIT;
                ST_RD_WAIT: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign ram_cs    = (state == ST_CMD);
    assign ram_we    = ram_cs & we_q;
    assign ram_oe    = ram_cs & ~we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign rsp_valid = (state == ST_RD_WAIT) ? (NUM_REQ'(1) << owner) : '0;
    assign rsp_rdata = (state == ST_RD_WAIT) ? ram_rdata : '0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb/tb_sp_ram_arbiter.sv - scoreboard bench for sp_ram_arbiter with behavioural RAM and arbitration model
module tb_sp_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NR = 2;

    typedef struct { bit we; bit [AW-1:0] addr; bit [DW-1:0] wdata; } txn_t;
    typedef struct { int cyc; int idx; } gexp_t;
    typedef struct { int cyc; bit we; bit [AW-1:0] addr; bit [DW-1:0] wdata; } cexp_t;
    typedef struct { int cyc; int idx; bit [DW-1:0] data; } rexp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_we = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             ram_cs, ram_we, ram_oe;
    logic [AW-1:0]    ram_addr;
    logic [DW-1:0]    ram_wdata;
    logic [DW-1:0]    ram_rdata;
    logic             busy;

    sp_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with registered read data
    bit [DW-1:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            if (ram_oe) ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Stimulus / reference model state (main process only)
    txn_t        txq [NR][$];
    gexp_t       eg [$];
    cexp_t       ec [$];
    rexp_t       er [$];
    bit [DW-1:0] model_mem [256];
    int          free_at = 0;
    int          rr_ptr = 0;
    bit          exp_busy = 1'b0;
    bit          rand_wd = 1'b0;
    bit          done = 1'b0;

    // Monitor state (monitor process only)
    int gi = 0, ci = 0, ri = 0;
    int checks = 0, errors = 0;
    bit finished = 1'b0;
    logic [NR-1:0] mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input bit [NR-1:0] pres, input int start);
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (start + k) % NR;
            if (pres[j]) return j;
        end
        return -1;
    endfunction

    // One clock of stimulus; predicts the handshake the DUT must perform this cycle
    task automatic step(input bit abandon, input bit [NR-1:0] hold_low);
        bit [NR-1:0] pres;
        int          w, start;
        txn_t        t;
        gexp_t       g;
        cexp_t       c;
        rexp_t       r;
        @(posedge clk);
        #1;
        exp_busy = (cyc < free_at);
        for (int i = 0; i < NR; i++) begin
            pres[i] = (txq[i].size() > 0) && !hold_low[i] && !(rand_wd && $urandom_range(0, 7) == 0);
            if (txq[i].size() > 0) begin
                t = txq[i][0];
                req_we[i] = t.we;
                req_addr[i*AW +: AW] = t.addr;
                req_wdata[i*DW +: DW] = t.wdata;
            end else begin
                req_we[i] = 1'($urandom_range(0, 1));
                req_addr[i*AW +: AW] = 8'($urandom_range(0, 255));
                req_wdata[i*DW +: DW] = 8'($urandom_range(0, 255));
            end
        end
        req_valid = pres;
`ifdef SP_RAM_ARB_RR_EN
        start = rr_ptr;
`else
        start = 0;
`endif
        if (cyc >= free_at) begin
            w = pick(pres, start);
            if (w >= 0) begin
                t = txq[w].pop_front();
                g.cyc = cyc; g.idx = w;
                eg.push_back(g);
                if (!abandon) begin
                    c.cyc = cyc + 1; c.we = t.we; c.addr = t.addr; c.wdata = t.wdata;
                    ec.push_back(c);
                    if (!t.we) begin
                        r.cyc = cyc + 2; r.idx = w; r.data = model_mem[t.addr];
                        er.push_back(r);
                    end
                end
                if (t.we) model_mem[t.addr] = t.wdata;
                free_at = cyc + (t.we ? 2 : 3);
                rr_ptr = (w + 1) % NR;
            end
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NR; i++) n += txq[i].size();
        return n;
    endfunction

    task automatic drain();
        int n = 0;
        while (pending() > 0 || cyc < free_at) begin
            step(1'b0, '0);
            n++;
            if (n > 2000) begin
                $display("FAIL drain_timeout at cycle %0d: got %0d pending expected 0", cyc, pending());
                $fatal(1);
            end
        end
        step(1'b0, '0);
    endtask

    task automatic push_txn(input int i, input bit we, input bit [AW-1:0] addr, input bit [DW-1:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        txq[i].push_back(t);
    endtask

    // Stimulus sequence
    initial begin
        req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = '0;
        free_at = 0;
        rr_ptr = 0;

        // requester 0: write 0xA5 to 0x10, read it back
        push_txn(0, 1'b1, 8'h10, 8'hA5);
        push_txn(0, 1'b0, 8'h10, 8'h00);
        drain();

        // withdrawal: valid held low for two idle cycles, then presented
        push_txn(0, 1'b1, 8'h20, 8'h77);
        step(1'b0, 2'b01);
        step(1'b0, 2'b01);
        drain();

        // requester 1 back-to-back write 0x3C to 0xFF then read
        push_txn(1, 1'b1, 8'hFF, 8'h3C);
        push_txn(1, 1'b0, 8'hFF, 8'h00);
        drain();

        // contention: both hold reads continuously
        for (int k = 0; k < 4; k++) begin
            push_txn(0, 1'b0, 8'h10, 8'($urandom_range(0, 255)));
            push_txn(1, 1'b0, 8'hFF, 8'($urandom_range(0, 255)));
        end
        drain();

        // randomized traffic with occasional withdrawals
        rand_wd = 1'b1;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (txq[i].size() < 3 && $urandom_range(0, 2) == 0)
                    push_txn(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            end
            step(1'b0, '0);
        end
        rand_wd = 1'b0;
        drain();

        // reset in the middle of a read command
        push_txn(0, 1'b0, 8'h10, 8'h00);
        step(1'b1, '0);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = '0;
        free_at = 0;
        rr_ptr = 0;
        for (int n = 0; n < 5; n++) step(1'b0, '0);

        // pointer restarts at 0 after reset
        push_txn(0, 1'b0, 8'h20, 8'h00);
        push_txn(1, 1'b0, 8'hFF, 8'h00);
        drain();

        done = 1'b1;
    end

    // Monitor: compares DUT outputs against queued expectations away from the rising edge
    always @(negedge clk or negedge rst_n) begin
        #1;
        if (!rst_n) begin
            check("reset_outputs",
                  {req_ready, rsp_valid, rsp_rdata, ram_cs, ram_we, ram_oe, ram_addr, ram_wdata, busy}, '0);
        end else if (!finished) begin
            while (gi < eg.size() && eg[gi].cyc < cyc) begin
                check("grant_missing", 64'(cyc), 64'(eg[gi].cyc));
                gi++;
            end
            mon_exp = '0;
            if (gi < eg.size() && eg[gi].cyc == cyc) begin
                mon_exp[eg[gi].idx] = 1'b1;
                gi++;
            end
            if (mon_exp != '0 || req_ready != '0) check("grant", req_ready, mon_exp);

            while (ci < ec.size() && ec[ci].cyc < cyc) begin
                check("cmd_missing", 64'(cyc), 64'(ec[ci].cyc));
                ci++;
            end
            if (ci < ec.size() && ec[ci].cyc == cyc) begin
                check("ram_cmd", {ram_cs, ram_we, ram_oe, ram_addr, ram_wdata},
                      {1'b1, ec[ci].we, !ec[ci].we, ec[ci].addr, ec[ci].wdata});
                ci++;
            end else if (ram_cs) begin
                check("ram_cs_unexpected", ram_cs, 1'b0);
            end else begin
                check("ram_idle_strobes", {ram_we, ram_oe}, 2'b00);
            end

            while (ri < er.size() && er[ri].cyc < cyc) begin
                check("rsp_missing", 64'(cyc), 64'(er[ri].cyc));
                ri++;
            end
            mon_exp = '0;
            if (ri < er.size() && er[ri].cyc == cyc) begin
                mon_exp[er[ri].idx] = 1'b1;
                check("rsp", {rsp_valid, rsp_rdata}, {mon_exp, er[ri].data});
                ri++;
            end else if (rsp_valid != '0) begin
                check("rsp_unexpected", rsp_valid, '0);
            end

            check("busy", busy, exp_busy);

            if (done) begin
                check("grants_left", 64'(eg.size() - gi), 0);
                check("cmds_left", 64'(ec.size() - ci), 0);
                check("rsps_left", 64'(er.size() - ri), 0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                finished = 1'b1;
                $finish;
            end
        end
    end

endmodule
